exc_commit_unit: RTL and testbench

Exception-commit stage that drives the CP0 exception and MTC0 ports from the dual-issue pipeline's PMS stage. Each cycle it holds one instruction pair and resolves exceptions, interrupts and ERET across both slots with fixed priority. On a commit it raises single-cycle CP0 strobes, then issues a registered pipeline flush and redirect PC. Position: between the execute/memory stage and writeback; it is the sole writer of the CP0 control inputs.

---
 rtl/exc_commit_unit_pkg.sv | 60 ++++++
 rtl/exc_commit_unit_if.sv | 50 +++++
 rtl/exc_commit_unit_slot_sel.sv | 49 ++++
 rtl/exc_commit_unit.sv | 142 ++++++++++++++
 tb/tb_exc_commit_unit.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_commit_unit_pkg.sv
// Shared CPU definitions for the exception-commit stage: ExcCodes, CP0 addresses,
// the redirect vector, the stage FSM states and the slot/resolution structs.
package exc_commit_unit_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  // CP0 register addresses as {rd, sel}
  localparam logic [7:0] CP0_BADVADDR = {5'd8, 3'd0};
  localparam logic [7:0] CP0_COUNT    = {5'd9, 3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        eret;
    logic        mtc0_we;
  } slot_ctrl_t;

  typedef struct packed {
    slot_ctrl_t  ctl;
    logic [7:0]  c0_addr;
    logic [31:0] c0_wdata;
  } slot_t;

  typedef struct packed {
    logic        ex;
    logic        eret;
    logic [4:0]  excode;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] badvaddr;
    logic        int_taken;
    logic        commit1;
    logic        commit2;
    logic        we1;
    logic        we2;
  } resolve_t;

endpackage

// File: rtl/exc_commit_unit_if.sv
// Pair/CP0/downstream bundle of the exception-commit stage; master is the commit
// unit, slave is the surrounding pipeline and CP0.
interface exc_commit_unit_if;
  import exc_commit_unit_pkg::*;

  logic        in_valid;
  logic        in_ready;
  slot_t       s1;
  slot_t       s2;
  logic        has_int;
  logic [31:0] epc_res;

  logic        pms_ex;
  logic [4:0]  ex_type;
  logic        pms_bd;
  logic [31:0] pms_pc;
  logic [31:0] pms_badvaddr;
  logic        pms_eret;

  logic        inst1_mtc0_we;
  logic [7:0]  inst1_c0_addr;
  logic [31:0] inst1_c0_wdata;
  logic        inst2_mtc0_we;
  logic [7:0]  inst2_c0_addr;
  logic [31:0] inst2_c0_wdata;

  logic        out_valid;
  logic        out_ready;
  logic        out_s1_commit;
  logic        out_s2_commit;
  logic        flush;
  logic [31:0] flush_pc;

  modport master (
    input  in_valid, s1, s2, has_int, epc_res, out_ready,
    output in_ready, pms_ex, ex_type, pms_bd, pms_pc, pms_badvaddr, pms_eret,
           inst1_mtc0_we, inst1_c0_addr, inst1_c0_wdata,
           inst2_mtc0_we, inst2_c0_addr, inst2_c0_wdata,
           out_valid, out_s1_commit, out_s2_commit, flush, flush_pc
  );

  modport slave (
    output in_valid, s1, s2, has_int, epc_res, out_ready,
    input  in_ready, pms_ex, ex_type, pms_bd, pms_pc, pms_badvaddr, pms_eret,
           inst1_mtc0_we, inst1_c0_addr, inst1_c0_wdata,
           inst2_mtc0_we, inst2_c0_addr, inst2_c0_wdata,
           out_valid, out_s1_commit, out_s2_commit, flush, flush_pc
  );

endinterface

// File: rtl/exc_commit_unit_slot_sel.sv
// Combinational priority/kill resolution of one instruction pair:
// slot-1 exception/interrupt > slot-1 ERET > slot-2 exception > slot-2 ERET.
module exc_slot_sel
  import exc_commit_unit_pkg::*;
(
  input  slot_ctrl_t s1,
  input  slot_ctrl_t s2,
  input  logic       int_pending,
  output resolve_t   res
);

  logic s1_int;
  logic s1_exc;
  logic s1_eret;
  logic s2_exc;
  logic s2_eret;
  logic kill2;

  // An interrupt rides on a clean slot 1 so EPC points at the first unretired instruction
  assign s1_int  = int_pending && s1.valid && !s1.ex;
  assign s1_exc  = (s1.valid && s1.ex) || s1_int;
  assign s1_eret = s1.valid && s1.eret && !s1_exc;
  assign kill2   = s1_exc || s1_eret;
  assign s2_exc  = s2.valid && s2.ex && !kill2;
  assign s2_eret = s2.valid && s2.eret && !s2.ex && !kill2;

  always_comb begin
    res           = '0;
    res.ex        = s1_exc || s2_exc;
    res.eret      = s1_eret || s2_eret;
    res.int_taken = s1_int;
    if (s1_exc || s1_eret) begin
      res.excode   = s1.ex ? s1.excode : EXC_INT;
      res.bd       = s1.bd;
      res.pc       = s1.pc;
      res.badvaddr = s1.badvaddr;
    end else if (s2_exc || s2_eret) begin
      res.excode   = s2.excode;
      res.bd       = s2.bd;
      res.pc       = s2.pc;
      res.badvaddr = s2.badvaddr;
    end
    res.commit1 = s1.valid && !s1_exc;
    res.we1     = s1.valid && s1.mtc0_we && !s1_exc;
    res.commit2 = s2.valid && !s2.ex && !kill2;
    res.we2     = s2.valid && s2.mtc0_we && !s2.ex && !kill2;
  end

endmodule

// File: rtl/exc_commit_unit.sv
// Exception-commit stage: holds one pair, raises single-cycle CP0 strobes on fire,
// then a one-cycle registered flush with redirect PC; stalls while out_ready is low.
module exc_commit_unit
  import exc_commit_unit_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  exc_commit_unit_if.master  bus
);

  state_t      state_q;
  state_t      state_d;
  slot_t       s1_q;
  slot_t       s2_q;
  logic        int_pending_q;
  logic        flush_eret_q;
  resolve_t    res;

  logic        fire;
  logic        redirect;
  logic        in_ready;
  logic        accept;
  logic        we1;
  logic        we2;
  logic        flushing;
  logic [31:0] flush_pc;

  // Last-value holds for data outputs between strobes
  logic [4:0]  ex_type_q;
  logic        bd_q;
  logic [31:0] pc_q;
  logic [31:0] badvaddr_q;
  logic [7:0]  c0_addr1_q;
  logic [31:0] c0_wdata1_q;
  logic [7:0]  c0_addr2_q;
  logic [31:0] c0_wdata2_q;
  logic [31:0] flush_pc_q;

  exc_slot_sel u_sel (
    .s1          (s1_q.ctl),
    .s2          (s2_q.ctl),
    .int_pending (int_pending_q),
    .res         (res)
  );

  always_comb begin
    state_d  = state_q;
    fire     = 1'b0;
    redirect = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = ST_FULL;
      end
      ST_FULL: begin
        fire     = bus.out_ready;
        redirect = fire && (res.ex || res.eret);
        in_ready = fire && !redirect;
        if (redirect)  state_d = ST_FLUSH;
        else if (fire) state_d = bus.in_valid ? ST_FULL : ST_EMPTY;
      end
      ST_FLUSH: state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  assign accept   = bus.in_valid && in_ready;
  assign we1      = fire && res.we1;
  assign we2      = fire && res.we2;
  assign flushing = (state_q == ST_FLUSH);
  // EPC is read in the flush cycle so a same-pair slot-1 MTC0 EPC is already visible
  assign flush_pc = flushing ? (flush_eret_q ? bus.epc_res : EXC_VECTOR) : flush_pc_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_EMPTY;
      s1_q          <= '0;
      s2_q          <= '0;
      int_pending_q <= 1'b0;
      flush_eret_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_pending_q <= bus.has_int && !(fire && res.int_taken);
      if (accept) begin
        s1_q <= bus.s1;
        s2_q <= bus.s2;
      end
      if (redirect) flush_eret_q <= res.eret;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_type_q   <= '0;
      bd_q        <= 1'b0;
      pc_q        <= '0;
      badvaddr_q  <= '0;
      c0_addr1_q  <= '0;
      c0_wdata1_q <= '0;
      c0_addr2_q  <= '0;
      c0_wdata2_q <= '0;
      flush_pc_q  <= '0;
    end else begin
      if (redirect) begin
        ex_type_q  <= res.excode;
        bd_q       <= res.bd;
        pc_q       <= res.pc;
        badvaddr_q <= res.badvaddr;
      end
      if (we1) begin
        c0_addr1_q  <= s1_q.c0_addr;
        c0_wdata1_q <= s1_q.c0_wdata;
      end
      if (we2) begin
        c0_addr2_q  <= s2_q.c0_addr;
        c0_wdata2_q <= s2_q.c0_wdata;
      end
      if (flushing) flush_pc_q <= flush_pc;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = (state_q == ST_FULL);
  assign bus.pms_ex         = fire && res.ex;
  assign bus.pms_eret       = fire && res.eret;
  assign bus.ex_type        = redirect ? res.excode   : ex_type_q;
  assign bus.pms_bd         = redirect ? res.bd       : bd_q;
  assign bus.pms_pc         = redirect ? res.pc       : pc_q;
  assign bus.pms_badvaddr   = redirect ? res.badvaddr : badvaddr_q;
  assign bus.inst1_mtc0_we  = we1;
  assign bus.inst1_c0_addr  = we1 ? s1_q.c0_addr  : c0_addr1_q;
  assign bus.inst1_c0_wdata = we1 ? s1_q.c0_wdata : c0_wdata1_q;
  assign bus.inst2_mtc0_we  = we2;
  assign bus.inst2_c0_addr  = we2 ? s2_q.c0_addr  : c0_addr2_q;
  assign bus.inst2_c0_wdata = we2 ? s2_q.c0_wdata : c0_wdata2_q;
  assign bus.out_s1_commit  = fire && res.commit1;
  assign bus.out_s2_commit  = fire && res.commit2;
  assign bus.flush          = flushing;
  assign bus.flush_pc       = flush_pc;

endmodule

// File: tb/tb_exc_commit_unit.sv
// Directed bench for exc_commit_unit: a pair-level reference model checked every
// negedge, plus hand-computed literal expectations at key cycles.
module tb_exc_commit_unit;
  import exc_commit_unit_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  exc_commit_unit_if bus();
  exc_commit_unit dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic slot_t mk(input bit v, input logic [31:0] pc, input bit bd, input bit ex,
                               input logic [4:0] code, input logic [31:0] bv, input bit eret,
                               input bit we, input logic [7:0] addr, input logic [31:0] wd);
    slot_t s;
    s.ctl.valid = v;   s.ctl.pc = pc;         s.ctl.bd = bd;     s.ctl.ex = ex;
    s.ctl.excode = code; s.ctl.badvaddr = bv; s.ctl.eret = eret; s.ctl.mtc0_we = we;
    s.c0_addr = addr;  s.c0_wdata = wd;
    return s;
  endfunction

  function automatic slot_t clean(input logic [31:0] pc);
    return mk(1, pc, 0, 0, 5'd0, 32'd0, 0, 0, 8'd0, 32'd0);
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    bit ex; bit eret; logic [4:0] code; bit bd; logic [31:0] pc; logic [31:0] bv;
    bit int_taken; bit c1; bit c2; bit w1; bit w2;
  } exp_t;

  // Decide what the pair reports, following the stated priority list literally
  function automatic exp_t resolve(input slot_t a, input slot_t b, input bit ip);
    exp_t r;
    bit slot2_dead;
    r = '0;
    slot2_dead = 0;
    if (a.ctl.valid) begin
      if (a.ctl.ex || ip) begin
        r.ex = 1; r.code = a.ctl.ex ? a.ctl.excode : EXC_INT;
        r.int_taken = !a.ctl.ex;
        r.bd = a.ctl.bd; r.pc = a.ctl.pc; r.bv = a.ctl.badvaddr;
        slot2_dead = 1;
      end else begin
        r.c1 = 1; r.w1 = a.ctl.mtc0_we;
        if (a.ctl.eret) begin
          r.eret = 1; r.code = a.ctl.excode;
          r.bd = a.ctl.bd; r.pc = a.ctl.pc; r.bv = a.ctl.badvaddr;
          slot2_dead = 1;
        end else if (b.ctl.valid && (b.ctl.ex || b.ctl.eret)) begin
          r.ex = b.ctl.ex; r.eret = !b.ctl.ex; r.code = b.ctl.excode;
          r.bd = b.ctl.bd; r.pc = b.ctl.pc; r.bv = b.ctl.badvaddr;
        end
      end
    end
    if (!slot2_dead && b.ctl.valid && !b.ctl.ex) begin
      r.c2 = 1; r.w2 = b.ctl.mtc0_we;
    end
    return r;
  endfunction

  bit    m_full = 0, m_flush = 0, m_int = 0, m_eret = 0;
  slot_t m_s1 = '0, m_s2 = '0;

  always @(posedge clk or negedge resetn) begin
    exp_t e;
    bit f, take;
    if (!resetn) begin
      m_full = 0; m_flush = 0; m_int = 0; m_eret = 0;
    end else begin
      e    = resolve(m_s1, m_s2, m_int);
      f    = m_full && bus.out_ready;
      take = m_full ? (f && !(e.ex || e.eret)) : !m_flush;
      if (m_flush) m_flush = 0;
      else if (f && (e.ex || e.eret)) begin
        m_flush = 1; m_eret = e.eret; m_full = 0;
      end else if (bus.in_valid && take) begin
        m_full = 1; m_s1 = bus.s1; m_s2 = bus.s2;
      end else if (f) m_full = 0;
      m_int = bus.has_int && !(f && e.int_taken);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit f, red, rdy;
    e   = resolve(m_s1, m_s2, m_int);
    f   = m_full && bus.out_ready;
    red = f && (e.ex || e.eret);
    rdy = (!m_full && !m_flush) || (f && !red);
    chk("m_out_valid", 32'(bus.out_valid), 32'(m_full));
    chk("m_in_ready",  32'(bus.in_ready),  32'(rdy));
    chk("m_pms_ex",    32'(bus.pms_ex),    32'(f && e.ex));
    chk("m_pms_eret",  32'(bus.pms_eret),  32'(f && e.eret));
    chk("m_we1",       32'(bus.inst1_mtc0_we), 32'(f && e.w1));
    chk("m_we2",       32'(bus.inst2_mtc0_we), 32'(f && e.w2));
    chk("m_commit1",   32'(bus.out_s1_commit), 32'(f && e.c1));
    chk("m_commit2",   32'(bus.out_s2_commit), 32'(f && e.c2));
    chk("m_flush",     32'(bus.flush),     32'(m_flush));
    if (red) begin
      chk("m_ex_type",  32'(bus.ex_type), 32'(e.code));
      chk("m_pms_bd",   32'(bus.pms_bd),  32'(e.bd));
      chk("m_pms_pc",   bus.pms_pc,       e.pc);
      chk("m_badvaddr", bus.pms_badvaddr, e.bv);
    end
    if (f && e.w1) chk("m_c0_wdata1", bus.inst1_c0_wdata, m_s1.c0_wdata);
    if (f && e.w2) chk("m_c0_wdata2", bus.inst2_c0_wdata, m_s2.c0_wdata);
    if (m_flush) chk("m_flush_pc", bus.flush_pc, m_eret ? bus.epc_res : EXC_VECTOR);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair when the unit is ready; returns one tick after acceptance
  task automatic send(input slot_t a, input slot_t b);
    int g = 0;
    #1;
    while (!bus.in_ready) begin
      g++;
      if (g > 20) begin
        n_chk++; n_fail++;
        $display("FAIL send_timeout: in_ready never rose, expected 1");
        break;
      end
      tick(); #1;
    end
    bus.in_valid = 1; bus.s1 = a; bus.s2 = b;
    tick();
    bus.in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.s1 = '0; bus.s2 = '0; bus.has_int = 0;
    bus.epc_res = 32'h0; bus.out_ready = 1;
    #2;
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_pms_ex",    32'(bus.pms_ex), 32'd0);
    chk("rst_pms_pc",    bus.pms_pc, 32'd0);
    chk("rst_flush",     32'(bus.flush), 32'd0);
    chk("rst_flush_pc",  bus.flush_pc, 32'd0);
    chk("rst_c0_wdata1", bus.inst1_c0_wdata, 32'd0);
    #10 resetn = 1;
    tick();

    // Slot-1 ADEL kills slot-2 MTC0
    send(mk(1, 32'hBFC0_1000, 0, 1, EXC_ADEL, 32'h1, 0, 0, 8'd0, 32'd0),
         mk(1, 32'hBFC0_1004, 0, 0, 5'd0, 32'd0, 0, 1, CP0_STATUS, 32'h55));
    #2;
    chk("t1_pms_ex",   32'(bus.pms_ex), 32'd1);
    chk("t1_ex_type",  32'(bus.ex_type), 32'd4);
    chk("t1_pms_pc",   bus.pms_pc, 32'hBFC0_1000);
    chk("t1_badvaddr", bus.pms_badvaddr, 32'h1);
    chk("t1_we2",      32'(bus.inst2_mtc0_we), 32'd0);
    chk("t1_commit2",  32'(bus.out_s2_commit), 32'd0);
    tick(); #2;
    chk("t1_flush",    32'(bus.flush), 32'd1);
    chk("t1_flush_pc", bus.flush_pc, 32'hBFC0_0380);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd0);
    tick();

    // Slot-1 MTC0 EPC then slot-2 ERET picks up the new EPC
    send(mk(1, 32'h8000_0100, 0, 0, 5'd0, 32'd0, 0, 1, CP0_EPC, 32'hBFC0_2000),
         mk(1, 32'h8000_0104, 0, 0, 5'd0, 32'd0, 1, 0, 8'd0, 32'd0));
    #2;
    chk("t2_we1",      32'(bus.inst1_mtc0_we), 32'd1);
    chk("t2_c0_addr1", 32'(bus.inst1_c0_addr), 32'(CP0_EPC));
    chk("t2_pms_eret", 32'(bus.pms_eret), 32'd1);
    chk("t2_pms_ex",   32'(bus.pms_ex), 32'd0);
    chk("t2_commit2",  32'(bus.out_s2_commit), 32'd1);
    tick();
    bus.epc_res = 32'hBFC0_2000;
    #2;
    chk("t2_flush_pc", bus.flush_pc, 32'hBFC0_2000);
    tick();

    // Interrupt on a clean slot 1
    bus.has_int = 1;
    tick();
    send(clean(32'h8000_1000), clean(32'h8000_1004));
    #2;
    chk("t3_pms_ex",   32'(bus.pms_ex), 32'd1);
    chk("t3_ex_type",  32'(bus.ex_type), 32'd0);
    chk("t3_pms_pc",   bus.pms_pc, 32'h8000_1000);
    chk("t3_commit1",  32'(bus.out_s1_commit), 32'd0);
    bus.has_int = 0;
    tick(); tick();

    // Slot-2 SYSCALL in delay slot, slot 1 commits with its MTC0
    send(mk(1, 32'h8000_2000, 0, 0, 5'd0, 32'd0, 0, 1, CP0_STATUS, 32'h1),
         mk(1, 32'h8000_2004, 1, 1, EXC_SYS, 32'd0, 0, 0, 8'd0, 32'd0));
    #2;
    chk("t4_commit1",  32'(bus.out_s1_commit), 32'd1);
    chk("t4_we1",      32'(bus.inst1_mtc0_we), 32'd1);
    chk("t4_ex_type",  32'(bus.ex_type), 32'd8);
    chk("t4_pms_bd",   32'(bus.pms_bd), 32'd1);
    chk("t4_pms_pc",   bus.pms_pc, 32'h8000_2004);
    tick(); tick();

    // Stall for 3 cycles, then one fire; has_int rises with that fire
    bus.out_ready = 0;
    send(clean(32'h8000_3000), clean(32'h8000_3004));
    bus.in_valid = 1; bus.s1 = clean(32'h8000_3008); bus.s2 = clean(32'h8000_300C);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t5_stall_ex",     32'(bus.pms_ex), 32'd0);
      chk("t5_stall_commit", 32'(bus.out_s1_commit), 32'd0);
      chk("t5_stall_ready",  32'(bus.in_ready), 32'd0);
      chk("t5_stall_valid",  32'(bus.out_valid), 32'd1);
      tick();
    end
    bus.out_ready = 1; bus.has_int = 1;
    #2;
    chk("t5_fire_commit1", 32'(bus.out_s1_commit), 32'd1);
    chk("t5_fire_pms_ex",  32'(bus.pms_ex), 32'd0);
    chk("t5_fire_ready",   32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 0; bus.has_int = 0;
    #2;
    chk("t6_next_int",     32'(bus.pms_ex), 32'd1);
    chk("t6_next_pc",      bus.pms_pc, 32'h8000_3008);
    tick(); tick();

    // Back-to-back clean pairs at full throughput
    #1;
    bus.in_valid = 1; bus.s1 = clean(32'h8000_4000); bus.s2 = clean(32'h8000_4004);
    tick();
    bus.s1 = clean(32'h8000_4008); bus.s2 = clean(32'h8000_400C);
    #2;
    chk("t7_b2b_commit2", 32'(bus.out_s2_commit), 32'd1);
    chk("t7_b2b_ready",   32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 0;
    #2;
    chk("t7_b2b_commit1", 32'(bus.out_s1_commit), 32'd1);
    tick();

    // Both slots except: only slot 1 reported
    send(mk(1, 32'h8000_5000, 0, 1, EXC_OV, 32'd0, 0, 0, 8'd0, 32'd0),
         mk(1, 32'h8000_5004, 0, 1, EXC_RI, 32'd0, 0, 0, 8'd0, 32'd0));
    #2;
    chk("t8_ex_type", 32'(bus.ex_type), 32'h0C);
    chk("t8_pms_pc",  bus.pms_pc, 32'h8000_5000);
    tick(); tick();

    // Slot-1 ERET beats slot-2 exception
    bus.epc_res = 32'h8000_6100;
    send(mk(1, 32'h8000_6000, 0, 0, 5'd0, 32'd0, 1, 0, 8'd0, 32'd0),
         mk(1, 32'h8000_6004, 0, 1, EXC_ADES, 32'h3, 0, 0, 8'd0, 32'd0));
    #2;
    chk("t9_pms_eret", 32'(bus.pms_eret), 32'd1);
    chk("t9_pms_ex",   32'(bus.pms_ex), 32'd0);
    chk("t9_commit1",  32'(bus.out_s1_commit), 32'd1);
    tick(); #2;
    chk("t9_flush_pc", bus.flush_pc, 32'h8000_6100);
    tick();

    // Reset asserted mid-flush aborts it
    send(mk(1, 32'h8000_7000, 0, 1, EXC_BP, 32'd0, 0, 0, 8'd0, 32'd0), '0);
    #2;
    chk("t10_ex_type", 32'(bus.ex_type), 32'd9);
    tick(); #1;
    chk("t10_flush", 32'(bus.flush), 32'd1);
    resetn = 0;
    #1;
    chk("t10_rst_flush",    32'(bus.flush), 32'd0);
    chk("t10_rst_flush_pc", bus.flush_pc, 32'd0);
    chk("t10_rst_pms_pc",   bus.pms_pc, 32'd0);
    chk("t10_rst_ex_type",  32'(bus.ex_type), 32'd0);
    chk("t10_rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick(); #2;
    resetn = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); #2;
      chk("t10_no_flush", 32'(bus.flush), 32'd0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
